viterbi_bmu_seq: RTL and testbench

- Branch-metric sequencer directly upstream of the Viterbi path-metric unit in the K=3, rate-1/2 hard-decision decoder.
- Buffers received 2-bit code symbols in a small FIFO.
- For each symbol, walks the 8 trellis transitions (4 states x 2 input bits) in fixed 8-cycle slots.
- Per transition, drives currentState, inputBit and the 3-bit Hamming distance between the received and expected code bits.

---
 rtl/viterbi_bmu_seq.sv | 158 +++++++++++++++
 tb/tb_viterbi_bmu_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_bmu_seq.sv
// viterbi_bmu_seq
// Branch-metric sequencer for the K=3, rate-1/2 hard-decision Viterbi decoder.
// Received 2-bit code symbols are queued in a small FIFO. Every 8-cycle slot
// takes one symbol and walks the 8 trellis transitions (4 states x 2 input
// bits). For each transition it presents the source state, the hypothesised
// input bit and the Hamming distance between received and expected code bits.
//
// Optional build macro: VITERBI_BMU_ERASURE_EN
//   defined   : FIFO stores {sym_erase, sym_data}; erased bits add 0 distance
//   undefined : FIFO stores sym_data only; sym_erase is ignored
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   sym_valid/ready   upstream handshake (ready = FIFO not full)
//   sym_data[1:0]     received code bits, [1]=c0, [0]=c1
//   sym_erase[1:0]    per-bit erasure flags (erasure build only)
//   flush             synchronous clear of FIFO and current slot
//   currentState      trellis source state {s[1], s[0]} of current transition
//   inputBit          hypothesised input bit of current transition
//   hamming_dist      branch metric, 0..2
//   bm_valid          current slot carries a real symbol
//   bm_first/bm_last  first / last transition of a valid slot
//   fifo_level        entries currently held in the FIFO
module viterbi_bmu_seq #(
    parameter logic [2:0] G0         = 3'b111,
    parameter logic [2:0] G1         = 3'b101,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sym_valid,
    output logic                          sym_ready,
    input  logic [1:0]                    sym_data,
    input  logic [1:0]                    sym_erase,
    input  logic                          flush,
    output logic [1:0]                    currentState,
    output logic                          inputBit,
    output logic [2:0]                    hamming_dist,
    output logic                          bm_valid,
    output logic                          bm_first,
    output logic                          bm_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

`ifdef VITERBI_BMU_ERASURE_EN
    localparam int SW = 4;
    logic [SW-1:0] wr_sym;
    assign wr_sym = {sym_erase, sym_data};
`else
    localparam int SW = 2;
    logic [SW-1:0] wr_sym;
    logic          unused_erase;
    assign wr_sym       = sym_data;
    assign unused_erase = ^sym_erase;
`endif

    logic [2:0]    step_q, step_d;
    logic          active_q, active_d;
    logic [SW-1:0] cur_sym_q, cur_sym_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [SW-1:0] mem_q [FIFO_DEPTH];

    logic full;
    logic push;
    logic pop;
    logic slot_end;

    always_comb begin
        full     = (count_q == LW'(FIFO_DEPTH));
        push     = sym_valid && !full && !flush;
        slot_end = (step_q == 3'd7);
        // Pop decision uses the level before this edge, so a same-edge push
        // into an empty FIFO waits for the following slot.
        pop      = slot_end && (count_q != '0) && !flush;

        step_d    = step_q + 3'd1;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        active_d  = active_q;
        cur_sym_d = cur_sym_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            active_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (slot_end) begin
                active_d = pop;
                if (pop) begin
                    cur_sym_d = mem_q[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + AW'(1);
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // step is free-running so the slot cadence stays locked to the PMU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q    <= '0;
            active_q  <= 1'b0;
            cur_sym_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            step_q    <= step_d;
            active_q  <= active_d;
            cur_sym_q <= cur_sym_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_sym;
        end
    end

    logic [1:0] code_bits;
    logic [1:0] diff;

    always_comb begin
        code_bits = {^(G0 & {step_q[0], step_q[2:1]}),
                     ^(G1 & {step_q[0], step_q[2:1]})};
        diff      = code_bits ^ cur_sym_q[1:0];
`ifdef VITERBI_BMU_ERASURE_EN
        diff      = diff & ~cur_sym_q[3:2];
`endif
    end

    assign currentState = step_q[2:1];
    assign inputBit     = step_q[0];
    assign hamming_dist = active_q ? ({2'b00, diff[1]} + {2'b00, diff[0]}) : 3'd0;
    assign bm_valid     = active_q;
    assign bm_first     = active_q && (step_q == 3'd0);
    assign bm_last      = active_q && slot_end;
    assign sym_ready    = !full;
    assign fifo_level   = count_q;

endmodule

// File: tb/tb_viterbi_bmu_seq.sv
module tb_viterbi_bmu_seq;

    localparam int         DEPTH = 4;
    localparam logic [2:0] TB_G0 = 3'b111;
    localparam logic [2:0] TB_G1 = 3'b101;

    logic       clk;
    logic       rst_n;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] sym_data;
    logic [1:0] sym_erase;
    logic       flush;
    logic [1:0] currentState;
    logic       inputBit;
    logic [2:0] hamming_dist;
    logic       bm_valid;
    logic       bm_first;
    logic       bm_last;
    logic [2:0] fifo_level;

    viterbi_bmu_seq #(.G0(TB_G0), .G1(TB_G1), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym_data     (sym_data),
        .sym_erase    (sym_erase),
        .flush        (flush),
        .currentState (currentState),
        .inputBit     (inputBit),
        .hamming_dist (hamming_dist),
        .bm_valid     (bm_valid),
        .bm_first     (bm_first),
        .bm_last      (bm_last),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: slot position, symbol queue, current slot contents.
    int         m_step;
    logic [3:0] m_q[$];
    bit         m_active;
    logic [3:0] m_cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected metric from the encoder shift register {u, s1, s0} and the
    // generator taps; erased bits are ignored in the erasure build.
    function automatic int ref_dist(input int stp, input logic [3:0] sym);
        int         u, s1, s0, c0, c1, d;
        bit         e0, e1;
        logic [2:0] sreg;
        u    = stp % 2;
        s1   = (stp / 2) / 2;
        s0   = (stp / 2) % 2;
        sreg = 3'(u * 4 + s1 * 2 + s0);
        c0   = $countones(sreg & TB_G0) % 2;
        c1   = $countones(sreg & TB_G1) % 2;
`ifdef VITERBI_BMU_ERASURE_EN
        e0 = sym[3];
        e1 = sym[2];
`else
        e0 = 1'b0;
        e1 = 1'b0;
`endif
        d = 0;
        if (c0 != int'(sym[1]) && !e0) d++;
        if (c1 != int'(sym[0]) && !e1) d++;
        return d;
    endfunction

    task automatic model_reset();
        m_step   = 0;
        m_q.delete();
        m_active = 1'b0;
        m_cur    = '0;
    endtask

    task automatic check_outputs();
        check("sym_ready",    sym_ready,    (m_q.size() < DEPTH) ? 1 : 0);
        check("fifo_level",   fifo_level,   m_q.size());
        check("bm_valid",     bm_valid,     m_active ? 1 : 0);
        check("bm_first",     bm_first,     (m_active && m_step == 0) ? 1 : 0);
        check("bm_last",      bm_last,      (m_active && m_step == 7) ? 1 : 0);
        check("currentState", currentState, m_step / 2);
        check("inputBit",     inputBit,     m_step % 2);
        check("hamming_dist", hamming_dist, m_active ? ref_dist(m_step, m_cur) : 0);
    endtask

    task automatic tick(input bit v, input logic [1:0] d, input logic [1:0] e,
                        input bit f, output bit acc);
        sym_valid = v;
        sym_data  = d;
        sym_erase = e;
        flush     = f;
        acc = v && !f && (m_q.size() < DEPTH);
        @(posedge clk);
        if (f) begin
            m_q.delete();
            m_active = 1'b0;
        end else begin
            if (m_step == 7) begin
                if (m_q.size() > 0) begin
                    m_cur    = m_q.pop_front();
                    m_active = 1'b1;
                end else begin
                    m_active = 1'b0;
                end
            end
            if (acc) m_q.push_back({e, d});
        end
        m_step = (m_step + 1) % 8;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(1'b0, 2'b00, 2'b00, 1'b0, a);
    endtask

    task automatic push1(input logic [1:0] d);
        bit a;
        tick(1'b1, d, 2'b00, 1'b0, a);
        check("push_accept", a ? 1 : 0, 1);
    endtask

    // Run a valid slot and compare its metric sequence against a fixed table.
    task automatic check_slot(input string tag, input int t0, input int t1, input int t2,
                              input int t3, input int t4, input int t5,
                              input int t6, input int t7);
        int tbl[8];
        int guard;
        tbl = '{t0, t1, t2, t3, t4, t5, t6, t7};
        guard = 0;
        while (!(m_active && m_step == 0) && guard < 20) begin
            idle(1);
            guard++;
        end
        check({tag, "_align"}, (m_active && m_step == 0) ? 1 : 0, 1);
        for (int i = 0; i < 8; i++) begin
            check(tag, hamming_dist, tbl[i]);
            if (i == 0) check({tag, "_first"}, bm_first, 1);
            if (i == 7) check({tag, "_last"},  bm_last,  1);
            if (i < 7) idle(1);
        end
    endtask

    initial begin
        bit         acc;
        int         guard, n, cyc;
        logic [1:0] d;

        sym_valid = 1'b0;
        sym_data  = 2'b00;
        sym_erase = 2'b00;
        flush     = 1'b0;
        rst_n     = 1'b1;
        model_reset();

        // Reset, then idle.
        #2 rst_n = 1'b0;
        #1 check_outputs();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        idle(16);

        // Single 00 symbol pushed at step 2.
        guard = 0;
        while (m_step != 2 && guard < 10) begin idle(1); guard++; end
        push1(2'b00);
        check_slot("dist00", 0, 2, 2, 0, 1, 1, 1, 1);
        idle(1);
        check("bubble_after_00", bm_valid, 0);
        idle(6);

        // Back-to-back 11 then 10.
        push1(2'b11);
        push1(2'b10);
        check_slot("dist11", 2, 0, 0, 2, 1, 1, 1, 1);
        idle(1);
        check_slot("dist10", 1, 1, 1, 1, 0, 2, 2, 0);
        idle(9);

        // Five symbols pushed from step 0 of a bubble slot.
        guard = 0;
        while (!(m_step == 0 && !m_active && m_q.size() == 0) && guard < 40) begin
            idle(1); guard++;
        end
        check("five_align", (m_step == 0 && !m_active) ? 1 : 0, 1);
        n = 0; cyc = 0;
        d = 2'($urandom_range(0, 3));
        while (n < 5 && cyc < 40) begin
            tick(1'b1, d, 2'b00, 1'b0, acc);
            cyc++;
            if (acc) begin
                n++;
                d = 2'($urandom_range(0, 3));
            end
            if (n == 4 && m_step >= 4) begin
                check("five_full_ready", sym_ready, 0);
                check("five_full_level", fifo_level, 4);
            end
        end
        check("five_cycles", cyc, 9);
        idle(48);

        // Push on the 7->0 edge with an empty FIFO.
        guard = 0;
        while (!(m_step == 7 && m_q.size() == 0) && guard < 20) begin idle(1); guard++; end
        push1(2'b01);
        check("edge_push_bubble", bm_valid, 0);
        idle(8);
        check("edge_push_next_slot", bm_valid, 1);
        idle(8);

        // Flush at step 3 of a valid slot with two queued.
        guard = 0;
        while (!(m_step == 6 && m_q.size() == 0) && guard < 20) begin idle(1); guard++; end
        push1(2'($urandom_range(0, 3)));
        push1(2'($urandom_range(0, 3)));
        push1(2'($urandom_range(0, 3)));
        idle(2);
        check("flush_setup_level", fifo_level, 2);
        check("flush_setup_valid", bm_valid, 1);
        tick(1'b1, 2'b11, 2'b00, 1'b1, acc);
        check("flush_valid", bm_valid, 0);
        check("flush_level", fifo_level, 0);
        check("flush_step", {currentState, inputBit}, 4);
        idle(10);

        // Randomised traffic with occasional flushes and erasures.
        for (int i = 0; i < 500; i++) begin
            tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 59) == 0, acc);
        end

        // Asynchronous reset at step 5 of a valid slot.
        guard = 0;
        while (!(m_active && m_step == 5) && guard < 100) begin
            tick(1'b1, 2'($urandom_range(0, 3)), 2'b00, 1'b0, acc);
            guard++;
        end
        check("reset_align", (m_active && m_step == 5) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("async_rst_valid", bm_valid, 0);
        check("async_rst_state", {currentState, inputBit}, 0);
        @(posedge clk);
        #1 check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        for (int i = 0; i < 40; i++) begin
            tick($urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 1'b0, acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
